// File: rtl/store_buffer_pkg.sv
// Shared definitions for the store buffer: store-type codes, queue entry layout
// and the alignment/byte-enable helpers used by store_align.
package store_buffer_pkg;

    // Store-type codes presented by the MEM stage on st_ctrl
    localparam logic [1:0] SB_none = 2'd0;
    localparam logic [1:0] SB_word = 2'd1;
    localparam logic [1:0] SB_hfwd = 2'd2;
    localparam logic [1:0] SB_byte = 2'd3;

    typedef struct packed {
        logic [29:0] addr;
        logic [3:0]  byteen;
        logic [31:0] data;
    } sb_entry_t;

    function automatic logic sb_misaligned(input logic [1:0] ctrl, input logic [1:0] addr_lo);
        logic mis;
        case (ctrl)
            SB_word: mis = (addr_lo != 2'b00);
            SB_hfwd: mis = addr_lo[0];
            SB_byte: mis = 1'b0;
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

    function automatic logic [3:0] sb_byteen(input logic [1:0] ctrl, input logic [1:0] addr_lo);
        logic [3:0] be;
        case (ctrl)
            SB_word: be = 4'b1111;
            SB_hfwd: be = addr_lo[1] ? 4'b1100 : 4'b0011;
            SB_byte: be = 4'b0001 << addr_lo;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/store_buffer_align.sv
// store_align: combinational byte-enable, lane replication and alignment check
// for one store presented by the MEM stage.
module store_align
    import store_buffer_pkg::*;
(
    input  logic [1:0]  st_ctrl,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata_in,
    output logic [3:0]  byteen,
    output logic [31:0] wdata_out,
    output logic        misaligned
);

    // Replicate the stored byte/halfword across every lane so the slave can
    // pick it up from whichever lane the byte enables select.
    always_comb begin
        byteen     = sb_byteen(st_ctrl, addr_lo);
        misaligned = sb_misaligned(st_ctrl, addr_lo);
        case (st_ctrl)
            SB_word: wdata_out = wdata_in;
            SB_hfwd: wdata_out = {2{wdata_in[15:0]}};
            SB_byte: wdata_out = {4{wdata_in[7:0]}};
            default: wdata_out = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/store_buffer.sv
// Store buffer: aligns MEM-stage stores, queues them in a DEPTH-entry FIFO and
// drains them over m_req/m_ack. Define STORE_BUFFER_FWD_EN for per-word load hazards.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        st_valid,
    input  logic [1:0]  st_ctrl,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_wdata,
    output logic        st_stall,
    output logic        st_exc,
    input  logic        ld_valid,
    input  logic [31:0] ld_addr,
    output logic        ld_conflict,
    output logic        m_req,
    output logic [31:0] m_addr,
    output logic [3:0]  m_byteen,
    output logic [31:0] m_wdata,
    input  logic        m_ack
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    sb_entry_t          mem_r [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   count_r;

    logic [3:0]         byteen_s;
    logic [31:0]        wdata_s;
    logic               misaligned_s;
    logic               store_s;
    logic               full_s;
    logic               empty_s;
    logic               push_s;
    logic               pop_s;
    logic               hazard_s;
    sb_entry_t          entry_s;
    sb_entry_t          head_s;

    store_align u_align (
        .st_ctrl    (st_ctrl),
        .addr_lo    (st_addr[1:0]),
        .wdata_in   (st_wdata),
        .byteen     (byteen_s),
        .wdata_out  (wdata_s),
        .misaligned (misaligned_s)
    );

    assign store_s = st_valid & (st_ctrl != SB_none);
    assign full_s  = (count_r == CNT_W'(DEPTH));
    assign empty_s = (count_r == {CNT_W{1'b0}});
    // Full refuses the push regardless of m_ack so st_stall never depends on the slave.
    assign push_s  = store_s & ~misaligned_s & ~full_s;
    assign pop_s   = ~empty_s & m_ack;

    assign st_exc   = store_s & misaligned_s;
    assign st_stall = store_s & ~misaligned_s & full_s;

    assign entry_s = '{addr: st_addr[31:2], byteen: byteen_s, data: wdata_s};
    assign head_s  = mem_r[rd_ptr_r];

    assign m_req    = ~empty_s;
    assign m_addr   = {head_s.addr, 2'b00};
    assign m_byteen = head_s.byteen;
    assign m_wdata  = head_s.data;

`ifdef STORE_BUFFER_FWD_EN
    logic [1:0] unused_ld_addr_s;
    assign unused_ld_addr_s = ld_addr[1:0];

    // Compare the load word against every occupied slot, walking from the head.
    always_comb begin
        hazard_s = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if ((CNT_W'(k) < count_r) &&
                (mem_r[rd_ptr_r + PTR_W'(k)].addr == ld_addr[31:2])) begin
                hazard_s = 1'b1;
            end else begin
                hazard_s = hazard_s;
            end
        end
    end
`else
    logic [31:0] unused_ld_addr_s;
    assign unused_ld_addr_s = ld_addr;

    // Without comparators any load waits for the buffer to drain completely.
    always_comb begin
        hazard_s = ~empty_s;
    end
`endif

    assign ld_conflict = ld_valid & hazard_s;

    // FIFO storage, pointers and occupancy; reset drops every queued store.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= entry_s;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule
